// File: rtl/npu_result_pkg.sv
// Shared constants for the NPU result readback path: host register map,
// STATUS bit layout, packer state encoding and a byte-lane insert helper.
package npu_result_pkg;

   localparam logic [1:0] ADDR_DATA      = 2'd0;
   localparam logic [1:0] ADDR_STATUS    = 2'd1;
   localparam logic [1:0] ADDR_BYTECOUNT = 2'd2;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERFLOW  = 2;
   localparam int STAT_DONE      = 3;
   localparam int STAT_COUNT_LSB = 16;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FLUSH   = 2'd1,
      DONE    = 2'd2
   } pack_state_e;

   // Little-endian placement: byte index k lands in bits [8k+7:8k].
   function automatic logic [31:0] insert_byte(input logic [31:0] acc,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
      logic [31:0] res;
      res = acc;
      res[{idx, 3'b000} +: 8] = b;
      return res;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Word FIFO with first-word-fall-through head output. Pointers wrap modulo
// DEPTH and a separate occupancy count keeps full and empty unambiguous.
module result_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
   assign do_pop  = pop & ~empty & ~clr;
   assign do_push = push & (~full | do_pop) & ~clr;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

endmodule

// File: rtl/npu_result_reader.sv
// Captures the NPU result byte stream, packs it little-endian into 32-bit
// words, buffers them and serves them to the host over the register bus.
module npu_result_reader
   import npu_result_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int EXPECTED_BYTES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  d_in,
   input  logic        d_valid,
   input  logic        clr,
   input  logic        chipselect,
   input  logic        read,
   input  logic [1:0]  address,
   output logic [31:0] readdata,
   output logic        done,
   output logic        overflow
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [15:0] EXP_CNT = 16'(EXPECTED_BYTES);

   pack_state_e state_q, state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_acc_q, word_acc_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic        overflow_q, overflow_d;
   logic [31:0] readdata_q, readdata_d;

   logic        push;
   logic [31:0] push_word;
   logic [31:0] acc_next;
   logic        host_rd;
   logic        pop;
   logic [31:0] fifo_rdata;
   logic [AW:0] fifo_count;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] status_word;

   result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .wdata (push_word),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Packer state register with counters and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= COLLECT;
         byte_idx_q <= '0;
         word_acc_q <= '0;
         byte_cnt_q <= '0;
         overflow_q <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         word_acc_q <= word_acc_d;
         byte_cnt_q <= byte_cnt_d;
         overflow_q <= overflow_d;
         readdata_q <= readdata_d;
      end
   end

   // Packer next-state: the accumulator is zeroed after every push so a
   // flushed partial word always carries zero upper bytes.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      word_acc_d = word_acc_q;
      byte_cnt_d = byte_cnt_q;
      push       = 1'b0;
      push_word  = word_acc_q;
      acc_next   = insert_byte(word_acc_q, byte_idx_q, d_in);
      case (state_q)
         COLLECT: begin
            if (d_valid) begin
               byte_cnt_d = byte_cnt_q + 16'd1;
               if (byte_idx_q == 2'd3) begin
                  push       = 1'b1;
                  push_word  = acc_next;
                  word_acc_d = '0;
                  byte_idx_d = '0;
               end else begin
                  word_acc_d = acc_next;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
               if (byte_cnt_q + 16'd1 == EXP_CNT)
                  state_d = (byte_idx_q == 2'd3) ? DONE : FLUSH;
            end
         end
         FLUSH: begin
            push       = 1'b1;
            push_word  = word_acc_q;
            word_acc_d = '0;
            byte_idx_d = '0;
            state_d    = DONE;
         end
         DONE:    state_d = DONE;
         default: state_d = COLLECT;
      endcase
      if (clr) begin
         state_d    = COLLECT;
         byte_idx_d = '0;
         word_acc_d = '0;
         byte_cnt_d = '0;
         push       = 1'b0;
      end
   end

   // Host read decode, sticky overflow and registered read data.
   always_comb begin
      host_rd     = chipselect & read & ~clr;
      pop         = host_rd & (address == ADDR_DATA);
      status_word = '0;
      status_word[31:STAT_COUNT_LSB] = 16'(fifo_count);
      status_word[STAT_DONE]         = done;
      status_word[STAT_OVERFLOW]     = overflow_q;
      status_word[STAT_FULL]         = fifo_full;
      status_word[STAT_EMPTY]        = fifo_empty;
      overflow_d  = overflow_q | (push & fifo_full & ~pop);
      if (clr) overflow_d = 1'b0;
      readdata_d  = readdata_q;
      if (host_rd) begin
         case (address)
            ADDR_DATA:      readdata_d = fifo_empty ? 32'd0 : fifo_rdata;
            ADDR_STATUS:    readdata_d = status_word;
            ADDR_BYTECOUNT: readdata_d = {16'd0, byte_cnt_q};
            default:        readdata_d = 32'd0;
         endcase
      end
   end

   assign readdata = readdata_q;
   assign done     = (state_q == DONE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// Bench for npu_result_reader: instance A (DEPTH 16, 10 bytes) and
// instance B (DEPTH 2, 16 bytes) share one stimulus stream.
module tb_npu_result_reader;
   import npu_result_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  d_in;
   logic        d_valid;
   logic        clr;
   logic        chipselect;
   logic        read;
   logic [1:0]  address;
   logic [31:0] rd_a, rd_b;
   logic        done_a, done_b, ovf_a, ovf_b;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [9];
   logic [7:0]  bq [$];
   logic [31:0] wq [$];
   logic [31:0] w;
   logic [7:0]  b;
   int          n, nb;

   always #5 clk = ~clk;

   npu_result_reader #(.DEPTH(16), .EXPECTED_BYTES(10)) dut_a (
      .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .clr(clr),
      .chipselect(chipselect), .read(read), .address(address),
      .readdata(rd_a), .done(done_a), .overflow(ovf_a));

   npu_result_reader #(.DEPTH(2), .EXPECTED_BYTES(16)) dut_b (
      .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .clr(clr),
      .chipselect(chipselect), .read(read), .address(address),
      .readdata(rd_b), .done(done_b), .overflow(ovf_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      d_in = v; d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
   endtask

   task automatic host_rd(input logic [1:0] a);
      chipselect = 1'b1; read = 1'b1; address = a;
      tick();
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 9; i++) begin
         host_rd(tbl[i].addr);
         check($sformatf("%s_vec%0d", tag, i), rd_a, tbl[i].exp);
      end
   endtask

   initial begin
      tbl[0] = '{ADDR_STATUS,    32'h0003_0008};
      tbl[1] = '{ADDR_DATA,      32'h0403_0201};
      tbl[2] = '{ADDR_DATA,      32'h0807_0605};
      tbl[3] = '{ADDR_DATA,      32'h0000_0A09};
      tbl[4] = '{ADDR_STATUS,    32'h0000_0009};
      tbl[5] = '{ADDR_BYTECOUNT, 32'h0000_000A};
      tbl[6] = '{2'd3,           32'h0000_0000};
      tbl[7] = '{ADDR_DATA,      32'h0000_0000};
      tbl[8] = '{ADDR_STATUS,    32'h0000_0009};

      reset = 1'b1; d_in = '0; d_valid = 1'b0; clr = 1'b0;
      chipselect = 1'b0; read = 1'b0; address = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_readdata_a", rd_a, 32'd0);
      check("rst_done_a", 32'(done_a), 32'd0);
      check("rst_ovf_a", 32'(ovf_a), 32'd0);
      check("rst_done_b", 32'(done_b), 32'd0);
      host_rd(ADDR_STATUS);
      check("rst_status_a", rd_a, 32'h1);
      check("rst_status_b", rd_b, 32'h1);

      // back-to-back bytes with flush timing
      for (int i = 1; i <= 10; i++) send(8'(i));
      check("flush_done_t1", 32'(done_a), 32'd0);
      tick();
      check("flush_done_t2", 32'(done_a), 32'd1);
      run_table("b2b");

      // gapped bytes plus a surplus byte after done
      do_clr();
      for (int i = 1; i <= 10; i++) begin
         send(8'(i));
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (2) tick();
      send(8'h0B);
      tick();
      run_table("gap");

      // capture to FIFO latency
      do_clr();
      for (int i = 0; i < 3; i++) send(8'h40 + 8'(i));
      host_rd(ADDR_STATUS);
      check("lat_status_3B", rd_a, 32'h0000_0001);
      send(8'h43);
      host_rd(ADDR_STATUS);
      check("lat_status_4B", rd_a, 32'h0001_0000);

      // overflow on the two-word FIFO
      do_clr();
      for (int i = 0; i < 16; i++) begin
         send(8'h10 + 8'(i));
         if (i == 7)  check("ovf_after_w2", 32'(ovf_b), 32'd0);
         if (i == 11) check("ovf_after_w3", 32'(ovf_b), 32'd1);
      end
      check("b_done_full_t1", 32'(done_b), 32'd1);
      host_rd(ADDR_DATA);
      check("ovf_rd_w1", rd_b, 32'h1312_1110);
      host_rd(ADDR_DATA);
      check("ovf_rd_w2", rd_b, 32'h1716_1514);
      host_rd(ADDR_DATA);
      check("ovf_rd_empty", rd_b, 32'h0);
      host_rd(ADDR_STATUS);
      check("ovf_status_b", rd_b, 32'h0000_000D);

      // asynchronous reset with outputs active
      host_rd(ADDR_BYTECOUNT);
      check("pre_rst_bc_a", rd_a, 32'h0000_000A);
      check("pre_rst_bc_b", rd_b, 32'h0000_0010);
      send(8'h55);
      #3;
      reset = 1'b1;
      #1;
      check("arst_readdata_a", rd_a, 32'd0);
      check("arst_readdata_b", rd_b, 32'd0);
      check("arst_done_a", 32'(done_a), 32'd0);
      check("arst_ovf_b", 32'(ovf_b), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      host_rd(ADDR_STATUS);
      check("arst_status_b", rd_b, 32'h1);

      // push and pop together at full
      do_clr();
      for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
      host_rd(ADDR_STATUS);
      check("full_status_b", rd_b, 32'h0002_0002);
      for (int i = 8; i < 11; i++) send(8'h20 + 8'(i));
      d_in = 8'h2B; d_valid = 1'b1;
      chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
      tick();
      d_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
      check("pp_rd_w1", rd_b, 32'h2322_2120);
      check("pp_no_ovf", 32'(ovf_b), 32'd0);
      host_rd(ADDR_DATA);
      check("pp_rd_w2", rd_b, 32'h2726_2524);
      host_rd(ADDR_DATA);
      check("pp_rd_w3", rd_b, 32'h2B2A_2928);

      // clear after overflow and mid-packet
      do_clr();
      for (int i = 0; i < 12; i++) send(8'($urandom));
      check("clr_pre_ovf_b", 32'(ovf_b), 32'd1);
      check("clr_pre_done_a", 32'(done_a), 32'd1);
      do_clr();
      for (int i = 0; i < 6; i++) send(8'h60 + 8'(i));
      host_rd(ADDR_BYTECOUNT);
      check("clr_pre_bc", rd_a, 32'd6);
      clr = 1'b1; d_in = 8'h77; d_valid = 1'b1;
      tick();
      clr = 1'b0; d_valid = 1'b0;
      host_rd(ADDR_BYTECOUNT);
      check("clr_bc_a", rd_a, 32'd0);
      host_rd(ADDR_STATUS);
      check("clr_status_a", rd_a, 32'h1);
      check("clr_status_b", rd_b, 32'h1);
      check("clr_done_a", 32'(done_a), 32'd0);
      check("clr_ovf_b", 32'(ovf_b), 32'd0);

      // randomized packets against the reference model
      for (int it = 0; it < 20; it++) begin
         do_clr();
         bq.delete();
         wq.delete();
         n = $urandom_range(0, 14);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            send(b);
            repeat ($urandom_range(0, 3)) tick();
         end
         repeat (3) tick();
         nb = (n < 10) ? n : 10;
         for (int k = 0; k < nb; k += 4) begin
            if (k + 4 <= nb || nb == 10) begin
               w = '0;
               for (int j = 0; j < 4; j++)
                  if (k + j < nb) w[8*j +: 8] = bq[k+j];
               wq.push_back(w);
            end
         end
         host_rd(ADDR_BYTECOUNT);
         check($sformatf("rnd%0d_bc", it), rd_a, 32'(nb));
         host_rd(ADDR_STATUS);
         check($sformatf("rnd%0d_status", it), rd_a,
               {16'(wq.size()), 12'd0, (nb == 10), 1'b0, 1'b0, (wq.size() == 0)});
         check($sformatf("rnd%0d_done", it), 32'(done_a), 32'(nb == 10));
         for (int k = 0; k < wq.size(); k++) begin
            host_rd(ADDR_DATA);
            check($sformatf("rnd%0d_w%0d", it, k), rd_a, wq[k]);
         end
         host_rd(ADDR_DATA);
         check($sformatf("rnd%0d_drain", it), rd_a, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/npu_result_reader.md
# npu_result_reader

Host-side readback path for NPU results: the counterpart of the host-to-RAM write path. It captures the byte stream the NPU emits on `D_OUT`, packs bytes into 32-bit words, buffers them in a word FIFO and serves them to the host over the same 32-bit register bus that loads images and weights. It signals completion once the configured number of result bytes has been collected.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 32-bit words (power of two).
- `EXPECTED_BYTES`, 10: result bytes per inference, one per output class.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `d_in`  in  8  result byte from NPU `D_OUT`.
- `d_valid`  in  1  byte strobe; one byte captured per cycle while high.
- `clr`  in  1  synchronous clear of packer, FIFO, counters and flags.
- `chipselect`  in  1  host bus select.
- `read`  in  1  host read strobe.
- `address`  in  2  0 = DATA (pops FIFO), 1 = STATUS, 2 = BYTECOUNT.
- `readdata`  out  32  registered read data.
- `done`  out  1  sticky; set when `EXPECTED_BYTES` bytes have been captured.
- `overflow`  out  1  sticky; set when a packed word is dropped because the FIFO is full.

## Operation
- Packer: `byte_idx` (2 b) and `word_acc` (32 b). A byte captured at index k goes to `word_acc[8k+7:8k]`, so packing is little-endian.
- On the 4th byte, the complete word, including the current byte, is pushed to the FIFO and `byte_idx` returns to 0.
- `byte_cnt` (16 b) increments on each captured byte.
- When `byte_cnt` reaches `EXPECTED_BYTES`:
  - Any partial word is pushed with its unused upper bytes zero.
  - `done` is set.
  - Further `d_valid` bytes are ignored until `clr`.
- Packer states:
  - COLLECT: accepting bytes.
  - FLUSH: push of the partial word is pending. Lasts one cycle and applies only when `EXPECTED_BYTES % 4 ≠ 0`.
  - DONE: capture stopped.
- State transitions:
  - COLLECT→FLUSH on the last byte when the word is partial.
  - COLLECT→DONE on the last byte when the word is full.
  - FLUSH→DONE always.
  - Any state→COLLECT on `clr`.
- Host read at DATA: pops one word; `readdata` = head word. A read with the FIFO empty returns 0 and leaves all state unchanged.
- Host read at STATUS returns:
  - `[31:16]` count of words in the FIFO.
  - `[3]` `done`.
  - `[2]` `overflow`.
  - `[1]` full.
  - `[0]` empty.
- Host read at BYTECOUNT returns `{16'b0, byte_cnt}`.
- Address 3 returns 0.
- STATUS and BYTECOUNT reads have no side effects.
- FIFO full with a push:
  - Without a pop in the same cycle: the word is dropped and `overflow` is set.
  - With a pop in the same cycle: both complete and `overflow` is not set.
- FIFO empty with a push and a pop in the same cycle: the pop returns 0 and the pushed word is stored.
- `clr` outranks every simultaneous event: a push, pop or byte in the same cycle is discarded.

## Timing
- Reset values:
  - `readdata` = 0, `done` = 0, `overflow` = 0.
  - FIFO empty, `byte_cnt` = 0, `byte_idx` = 0, state COLLECT.
- Reset asserted mid-packet discards all data immediately (asynchronous).
- Capture → FIFO: the 4th byte at cycle t is visible in the FIFO (count, empty flag) at t+1.
- Flush: the last byte at t gives the partial word in the FIFO at t+2. `done` is high from t+1 when the last word is full, and from t+2 when a flush is needed.
- Read latency is 1: with `chipselect & read` at t, `readdata` is valid at t+1 and holds until the next read.
- Pop takes effect at the edge ending cycle t; STATUS read at t+1 reflects it.
- Pointers wrap modulo `DEPTH`; count is tracked separately (width log2(`DEPTH`)+1) so full and empty are unambiguous.

## Structure
- Package `npu_result_pkg` holds:
  - Address constants `ADDR_DATA`, `ADDR_STATUS`, `ADDR_BYTECOUNT`.
  - STATUS bit positions.
  - The packer state enum `{COLLECT, FLUSH, DONE}`.
- Sub-module `result_fifo`:
  - Parameterised synchronous word FIFO: push, pop, `wdata`, `rdata`, count, full, empty.
  - Asynchronous reset plus synchronous clear.
  - Reads first-word-fall-through internally; the top level registers `readdata`.
- Top level holds the packer FSM, counters, sticky flags and host read decode.

## Test plan
- Reset, then STATUS read → `0x00000001` (empty only); `done` = 0; `readdata` = 0.
- `EXPECTED_BYTES` = 10 with bytes 0x01..0x0A back-to-back, then three DATA reads:
  - Returns `0x04030201`, `0x08070605`, `0x00000A09`.
  - `done` is set 2 cycles after the last byte.
  - STATUS = `0x00000009`.
- Bytes arrive with gaps of 0–3 idle cycles, plus an 11th byte after `done` → words identical to the previous scenario; BYTECOUNT = 10.
- `DEPTH` = 2, `EXPECTED_BYTES` = 16, no reads:
  - `overflow` is set when word 3 is dropped.
  - DATA reads return only words 1 and 2.
  - Simultaneous push and pop at full → no overflow.
- DATA read on an empty FIFO → `readdata` = 0; count stays 0.
- Checks around clear and reset:
  - `clr` after 6 bytes → BYTECOUNT = 0, FIFO empty, `done` = 0, `overflow` = 0.
  - `reset` asserted mid-word → all outputs 0 without waiting for a clock edge.
